// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: reset defaults,
// fetch FSM encoding and the fetch-buffer entry layout.
package mips_pkg;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_FETCH = 2'b01;
  localparam logic [1:0] ST_DROP  = 2'b10;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry fetch buffer; entry 0 is always the head, so the consumer
// reads a register directly. Clear has priority over push and pop.
module fetch_skid_fifo
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  fetch_entry din,
  input  logic       pop,
  input  logic       clear,
  output fetch_entry head,
  output logic [1:0] count
);

  logic [1:0] count_r;
  fetch_entry mem0_r;
  fetch_entry mem1_r;
  logic       push_ok_s;
  logic       pop_ok_s;

  // Qualify requests against the current occupancy.
  always_comb begin
    pop_ok_s  = pop && (count_r != 2'd0);
    push_ok_s = push && ((count_r != 2'd2) || pop_ok_s);
  end

  // Storage and occupancy update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= 2'd0;
      mem0_r  <= '0;
      mem1_r  <= '0;
    end else if (clear) begin
      count_r <= 2'd0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10: begin
          if (count_r == 2'd0) mem0_r <= din;
          else                 mem1_r <= din;
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          mem0_r  <= mem1_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            mem0_r <= din;
          end else begin
            mem0_r <= mem1_r;
            mem1_r <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = mem0_r;
  assign count = count_r;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: PC register, single-outstanding imem
// handshake, redirect/drop handling and the IF/ID presentation mux.
module if_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_4_IF,
  output logic [31:0] instr_IF,
  output logic        fetch_valid
);

  logic [1:0]  state_r;
  logic [1:0]  state_nx_s;
  logic [31:0] pc_r;
  logic [31:0] req_addr_r;
  logic        held_r;
  logic        ack_s;
  logic        push_s;
  logic        pop_s;
  fetch_entry  push_data_s;
  fetch_entry  head_s;
  logic [1:0]  count_s;

  // Request launch/hold; a held request keeps its launch address even
  // after a redirect has moved pc elsewhere.
  always_comb begin
    imem_req = 1'b0;
    case (state_r)
      ST_FETCH: imem_req = held_r || ((count_s != 2'd2) && !redirect);
      ST_DROP:  imem_req = 1'b1;
      default:  imem_req = 1'b0;
    endcase
    if (held_r) imem_addr = req_addr_r;
    else        imem_addr = pc_r;
    ack_s             = imem_req && imem_ack;
    push_s            = ack_s && (state_r == ST_FETCH) && !redirect;
    pop_s             = (count_s != 2'd0) && !stall && !redirect;
    push_data_s.pc    = imem_addr;
    push_data_s.instr = imem_rdata;
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: state_nx_s = ST_FETCH;
      ST_FETCH: begin
        if (redirect && held_r && !imem_ack) state_nx_s = ST_DROP;
        else                                  state_nx_s = ST_FETCH;
      end
      ST_DROP: begin
        if (ack_s) state_nx_s = ST_FETCH;
        else       state_nx_s = ST_DROP;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM, PC and handshake bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_PC;
      req_addr_r <= RESET_PC;
      held_r     <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      held_r  <= imem_req && !imem_ack;
      if (imem_req && !held_r) req_addr_r <= pc_r;
      if (redirect)    pc_r <= word_align(redirect_pc);
      else if (push_s) pc_r <= imem_addr + 32'd4;
    end
  end

  fetch_skid_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .din   (push_data_s),
    .pop   (pop_s),
    .clear (redirect),
    .head  (head_s),
    .count (count_s)
  );

  // Present the head entry, or a bubble when nothing is buffered.
  always_comb begin
    fetch_valid = (count_s != 2'd0);
    if (fetch_valid) begin
      PC_4_IF  = head_s.pc + 32'd4;
      instr_IF = head_s.instr;
    end else begin
      PC_4_IF  = 32'd0;
      instr_IF = NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: a wait-state memory model, an expected
// queue of {PC+4, instr} and a monitor that checks every consumed entry.
module tb_if_fetch;
  import mips_pkg::*;

  localparam logic [31:0] NOP = 32'h0BAD_0BAD;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC_4_IF;
  logic [31:0] instr_IF;
  logic        fetch_valid;

  logic        mem_en;
  int          waits;
  int          wcnt;
  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  int          n0;
  int          p0;
  logic [63:0] exp_q[$];
  logic [31:0] ack_log[$];

  if_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PC_4_IF(PC_4_IF),
    .instr_IF(instr_IF), .fetch_valid(fetch_valid)
  );

  always #5 clk = ~clk;

  // Memory: acks after 'waits' held cycles, word = addr ^ A5A5_0000.
  assign imem_ack   = mem_en && imem_req && (wcnt >= waits);
  assign imem_rdata = imem_ack ? (imem_addr ^ 32'hA5A5_0000) : 32'h0000_0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(posedge clk) begin
    if (rst && imem_req && imem_ack) ack_log.push_back(imem_addr);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = start + 32'(4 * i);
      exp_q.push_back({a + 32'd4, a ^ 32'hA5A5_0000});
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req},    32'd0);
    chk({tag, "_addr"},  imem_addr,            32'h0000_0000);
    chk({tag, "_valid"}, {31'd0, fetch_valid}, 32'd0);
    chk({tag, "_instr"}, instr_IF,             NOP);
    chk({tag, "_pc4"},   PC_4_IF,              32'd0);
  endtask

  task automatic hold_reset();
    @(posedge clk); #2; rst = 1'b0;
  endtask

  // Deassert mid-cycle; the next negedge is the second cycle after release.
  task automatic release_rst();
    @(negedge clk); #2; rst = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Monitor: every entry consumed by IF/ID must match the scoreboard head.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst && fetch_valid && !stall && !redirect) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_empty: got pc4 %h instr %h expected nothing at %0t",
                 PC_4_IF, instr_IF, $time);
      end else begin
        e = exp_q.pop_front();
        chk("mon_pc4", PC_4_IF, e[63:32]);
        chk("mon_instr", instr_IF, e[31:0]);
        pops++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    mem_en = 1'b1; waits = 0;
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst");

    // Zero-wait streaming from reset.
    push_seq(32'h0000_0000, 64);
    release_rst();
    #1 chk("idle_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0000_0000);
    chk("first_valid", {31'd0, fetch_valid}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stream_valid", {31'd0, fetch_valid}, 32'd1);
      chk("stream_req", {31'd0, imem_req}, 32'd1);
    end

    // Four stall cycles: head is address 0x18 throughout.
    cyc(); stall = 1'b1; n0 = ack_log.size();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_pc4", PC_4_IF, 32'h0000_001C);
      chk("stall_instr", instr_IF, 32'hA5A5_0018);
      if (i > 0) chk("stall_req", {31'd0, imem_req}, 32'd0);
      if (i < 3) cyc();
    end
    cyc(); stall = 1'b0;
    chk("stall_acks", 32'(ack_log.size() - n0), 32'd1);
    repeat (12) @(negedge clk);

    // Asynchronous reset while a request is held.
    cyc(); stall = 1'b1; mem_en = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    chk("pre_rst_valid", {31'd0, fetch_valid}, 32'd1);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("async_rst");

    // Three wait states, redirect in the first wait cycle.
    stall = 1'b0; mem_en = 1'b1; waits = 3;
    exp_q.delete();
    push_seq(32'h0000_0100, 16);
    release_rst();
    @(negedge clk);
    chk("w3_req", {31'd0, imem_req}, 32'd1);
    chk("w3_addr", imem_addr, 32'h0000_0000);
    cyc(); redirect = 1'b1; redirect_pc = 32'h0000_0103;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drop_req", {31'd0, imem_req}, 32'd1);
      chk("drop_addr", imem_addr, 32'h0000_0000);
      if (i > 0) chk("drop_valid", {31'd0, fetch_valid}, 32'd0);
      cyc(); redirect = 1'b0;
    end
    @(negedge clk);
    chk("tgt_req", {31'd0, imem_req}, 32'd1);
    chk("tgt_addr", imem_addr, 32'h0000_0100);
    chk("tgt_valid", {31'd0, fetch_valid}, 32'd0);
    p0 = pops;
    repeat (16) @(negedge clk);
    chk("drop_pops", {31'd0, (pops - p0) >= 3}, 32'd1);

    // Redirect coinciding with an ack that would fill entry 2.
    hold_reset();
    waits = 1; stall = 1'b1;
    exp_q.delete();
    push_seq(32'h0000_0200, 16);
    release_rst();
    repeat (3) @(negedge clk);
    chk("ra_pre_valid", {31'd0, fetch_valid}, 32'd1);
    chk("ra_pre_addr", imem_addr, 32'h0000_0004);
    cyc(); redirect = 1'b1; redirect_pc = 32'h0000_0202;
    @(negedge clk);
    chk("ra_ack_req", {31'd0, imem_req}, 32'd1);
    cyc(); redirect = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("ra_valid", {31'd0, fetch_valid}, 32'd0);
    chk("ra_instr", instr_IF, NOP);
    chk("ra_pc4", PC_4_IF, 32'd0);
    chk("ra_req", {31'd0, imem_req}, 32'd1);
    chk("ra_addr", imem_addr, 32'h0000_0200);
    p0 = pops;
    repeat (10) @(negedge clk);
    chk("ra_pops", {31'd0, (pops - p0) >= 2}, 32'd1);

    // PC wrap at the top of the address space.
    cyc(); waits = 0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    exp_q.delete();
    push_seq(32'hFFFF_FFFC, 8);
    @(negedge clk);
    cyc(); redirect = 1'b0;
    @(negedge clk);
    chk("wrap_req", {31'd0, imem_req}, 32'd1);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_addr1", imem_addr, 32'h0000_0000);
    chk("wrap_pc4", PC_4_IF, 32'h0000_0000);
    chk("wrap_instr", instr_IF, 32'h5A5A_FFFC);
    chk("wrap_valid", {31'd0, fetch_valid}, 32'd1);
    repeat (6) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
